// File: rtl/cpu_debug_monitor_if.sv
// Memory/CPU bus bundle for cpu_debug_monitor.
//
// Signals:
//   cpu_addr, cpu_wdata, cpu_we : CPU-side memory request.
//   mem_rdata                   : read data returned by the memory.
//   mem_addr, mem_we, mem_wdata : muxed request presented to the memory.
//
// Modports:
//   master : the monitor, which owns the memory port mux.
//   slave  : the surrounding system (CPU core plus memory).
interface cpu_debug_monitor_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/cpu_debug_monitor.sv
// Single-clock CPU step/run/dump sequencer with memory port mux and display word select.
//
// Ports:
//   clk, reset   : system clock, synchronous active-high reset.
//   step_btn     : debounced step level; rising edge steps the CPU or advances the dump pointer.
//   dump_btn     : debounced level; rising edge toggles dump mode.
//   run_sw       : 1 selects free-run mode.
//   disp_sel     : display source (0 rdata, 1 mem_addr, 2 cpu_wdata, 3 step_count).
//   bus          : CPU request / memory port bundle (master modport).
//   cpu_ce       : one-cycle CPU clock enable.
//   disp_word    : word for the display controller.
//   dump_active  : high while dumping.
//   step_count   : cpu_ce pulses since reset, wrapping at 16 bits.
//
// Optional feature, macro CPU_DEBUG_BREAKPOINT_EN: adds bp_addr/bp_en inputs and a sticky bp_hit
// output. A match in RUN (outside a cpu_ce cycle) stops to IDLE; a step event clears bp_hit.
module cpu_debug_monitor #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RUN_DIV    = 500,
    parameter int unsigned DUMP_START = 0,
    parameter int unsigned DUMP_END   = 2**ADDR_W - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_btn,
    input  logic                 dump_btn,
    input  logic                 run_sw,
    input  logic [1:0]           disp_sel,
    cpu_debug_monitor_if.master  bus,
`ifdef CPU_DEBUG_BREAKPOINT_EN
    input  logic [ADDR_W-1:0]    bp_addr,
    input  logic                 bp_en,
    output logic                 bp_hit,
`endif
    output logic                 cpu_ce,
    output logic [DATA_W-1:0]    disp_word,
    output logic                 dump_active,
    output logic [15:0]          step_count
);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StDump} state_e;

    state_e            state_q;
    logic              step_prev_q;
    logic              dump_prev_q;
    logic [DIV_W-1:0]  div_q;
    logic [ADDR_W-1:0] dump_ptr_q;
    logic              cpu_ce_q;
    logic              dump_active_q;
    logic [15:0]       step_count_q;

    logic step_ev;
    logic dump_ev;
    logic div_last;
    logic bp_stop;
    logic run_block;

    assign step_ev  = step_btn & ~step_prev_q;
    assign dump_ev  = dump_btn & ~dump_prev_q;
    assign div_last = (div_q == DIV_W'(RUN_DIV - 1));

`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic bp_hit_q;
    // Only sample the match between pulses so a breakpoint never cuts a pulse in half.
    assign bp_stop   = bp_en && (bus.cpu_addr == bp_addr) && !cpu_ce_q;
    // A latched breakpoint keeps IDLE from re-entering RUN until a step acknowledges it.
    assign run_block = bp_hit_q;
    assign bp_hit    = bp_hit_q;
`else
    assign bp_stop   = 1'b0;
    assign run_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            step_prev_q   <= 1'b0;
            dump_prev_q   <= 1'b0;
            div_q         <= '0;
            dump_ptr_q    <= ADDR_W'(DUMP_START);
            cpu_ce_q      <= 1'b0;
            dump_active_q <= 1'b0;
            step_count_q  <= '0;
`ifdef CPU_DEBUG_BREAKPOINT_EN
            bp_hit_q      <= 1'b0;
`endif
        end else begin
            step_prev_q <= step_btn;
            dump_prev_q <= dump_btn;
            cpu_ce_q    <= 1'b0;

`ifdef CPU_DEBUG_BREAKPOINT_EN
            if (state_q == StRun && !dump_ev && run_sw && bp_stop) begin
                bp_hit_q <= 1'b1;
            end else if (step_ev) begin
                bp_hit_q <= 1'b0;
            end
`endif

            unique case (state_q)
                StIdle: begin
                    if (dump_ev) begin
                        // Dump wins over a coincident step; the step is dropped.
                        state_q       <= StDump;
                        dump_active_q <= 1'b1;
                        dump_ptr_q    <= ADDR_W'(DUMP_START);
                    end else begin
                        if (step_ev) begin
                            cpu_ce_q     <= 1'b1;
                            step_count_q <= step_count_q + 16'd1;
                        end
                        if (run_sw && !run_block) begin
                            state_q <= StRun;
                            div_q   <= '0;
                        end
                    end
                end

                StRun: begin
                    if (dump_ev) begin
                        state_q       <= StDump;
                        dump_active_q <= 1'b1;
                        dump_ptr_q    <= ADDR_W'(DUMP_START);
                    end else if (!run_sw || bp_stop) begin
                        state_q <= StIdle;
                        div_q   <= '0;
                    end else if (div_last) begin
                        div_q        <= '0;
                        cpu_ce_q     <= 1'b1;
                        step_count_q <= step_count_q + 16'd1;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                StDump: begin
                    if (dump_ev) begin
                        dump_active_q <= 1'b0;
                        if (run_sw) begin
                            state_q <= StRun;
                            div_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (step_ev) begin
                        if (dump_ptr_q == ADDR_W'(DUMP_END)) begin
                            dump_ptr_q <= ADDR_W'(DUMP_START);
                        end else begin
                            dump_ptr_q <= dump_ptr_q + ADDR_W'(1);
                        end
                    end
                end

                default: begin
                    state_q       <= StIdle;
                    dump_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ce      = cpu_ce_q;
    assign dump_active = dump_active_q;
    assign step_count  = step_count_q;

    // Memory port mux: the dump pointer owns the address and writes are blocked while dumping.
    assign bus.mem_addr  = dump_active_q ? dump_ptr_q : bus.cpu_addr;
    assign bus.mem_we    = dump_active_q ? 1'b0 : bus.cpu_we;
    assign bus.mem_wdata = bus.cpu_wdata;

    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] count_ext;

    if (DATA_W > ADDR_W) begin : g_addr_zext
        assign addr_ext = {{(DATA_W - ADDR_W){1'b0}}, bus.mem_addr};
    end else begin : g_addr_trunc
        assign addr_ext = bus.mem_addr[DATA_W-1:0];
    end

    if (DATA_W > 16) begin : g_cnt_zext
        assign count_ext = {{(DATA_W - 16){1'b0}}, step_count_q};
    end else begin : g_cnt_trunc
        assign count_ext = step_count_q[DATA_W-1:0];
    end

    always_comb begin
        disp_word = bus.mem_rdata;
        unique case (disp_sel)
            2'd0:    disp_word = bus.mem_rdata;
            2'd1:    disp_word = addr_ext;
            2'd2:    disp_word = bus.cpu_wdata;
            2'd3:    disp_word = count_ext;
            default: disp_word = bus.mem_rdata;
        endcase
    end
endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Directed self-checking bench for cpu_debug_monitor (RUN_DIV=4, dump window 2..4).
module tb_cpu_debug_monitor;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned RUN_DIV    = 4;
    localparam int unsigned DUMP_START = 2;
    localparam int unsigned DUMP_END   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              step_btn;
    logic              dump_btn;
    logic              run_sw;
    logic [1:0]        disp_sel;
    logic              cpu_ce;
    logic [DATA_W-1:0] disp_word;
    logic              dump_active;
    logic [15:0]       step_count;
`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;
    logic              bp_hit;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_debug_monitor_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cpu_debug_monitor #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RUN_DIV   (RUN_DIV),
        .DUMP_START(DUMP_START),
        .DUMP_END  (DUMP_END)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_btn   (step_btn),
        .dump_btn   (dump_btn),
        .run_sw     (run_sw),
        .disp_sel   (disp_sel),
        .bus        (bus),
`ifdef CPU_DEBUG_BREAKPOINT_EN
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .bp_hit     (bp_hit),
`endif
        .cpu_ce     (cpu_ce),
        .disp_word  (disp_word),
        .dump_active(dump_active),
        .step_count (step_count)
    );

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        logic [19:0] mask;
        logic        ce_seen;

        reset          = 1'b1;
        step_btn       = 1'b0;
        dump_btn       = 1'b0;
        run_sw         = 1'b0;
        disp_sel       = 2'd0;
        bus.cpu_addr   = 8'h55;
        bus.cpu_wdata  = 16'h1234;
        bus.cpu_we     = 1'b0;
        bus.mem_rdata  = 16'h0000;
`ifdef CPU_DEBUG_BREAKPOINT_EN
        bp_addr = 8'h00;
        bp_en   = 1'b0;
`endif
        cyc(2);

        // Reset state.
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_dump_active", dump_active, 0);
        check("rst_step_count", step_count, 0);
        check("rst_mem_addr", bus.mem_addr, 8'h55);

        reset = 1'b0;
        cyc(2);

        // Single steps: one pulse per rising edge, one cycle after the edge.
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'b1;
            cyc();
            check("step_ce_first", cpu_ce, 1);
            pulses = 1;
            for (int k = 1; k < 10; k++) begin
                if (k == 3) step_btn = 1'b0;
                cyc();
                pulses += int'(cpu_ce);
            end
            check("step_pulses", pulses, 1);
        end
        check("step_count3", step_count, 3);
        disp_sel = 2'd3;
        #1;
        check("disp_count", disp_word, 16'h0003);

        // Free run: pulses every RUN_DIV cycles after entry; step events ignored.
        run_sw = 1'b1;
        cyc();
        mask = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 6) step_btn = 1'b1;
            if (c == 9) step_btn = 1'b0;
            cyc();
            mask[c-1] = cpu_ce;
        end
        check("run_pulse_mask", mask, 20'h88888);
        check("run_step_count", step_count, 8);
        run_sw = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            pulses += int'(cpu_ce);
        end
        check("run_stop_pulses", pulses, 0);

        // Dump: pointer walks 2,3,4,2,3, writes blocked, CPU held.
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 8'h77;
        dump_btn     = 1'b1;
        cyc();
        dump_btn = 1'b0;
        check("dump_active", dump_active, 1);
        check("dump_addr0", bus.mem_addr, 2);
        check("dump_we", bus.mem_we, 0);
        ce_seen = cpu_ce;
        begin
            logic [7:0] exp_addr [4];
            exp_addr[0] = 8'd3;
            exp_addr[1] = 8'd4;
            exp_addr[2] = 8'd2;
            exp_addr[3] = 8'd3;
            for (int s = 0; s < 4; s++) begin
                step_btn = 1'b1;
                cyc();
                ce_seen |= cpu_ce;
                check("dump_addr_step", bus.mem_addr, exp_addr[s]);
                if (s == 0) begin
                    disp_sel = 2'd1;
                    #1;
                    check("disp_addr", disp_word, 16'h0003);
                    disp_sel      = 2'd0;
                    bus.mem_rdata = 16'hBEEF;
                    #1;
                    check("disp_rdata", disp_word, 16'hBEEF);
                    disp_sel = 2'd2;
                    #1;
                    check("disp_wdata", disp_word, 16'h1234);
                end
                step_btn = 1'b0;
                cyc();
                ce_seen |= cpu_ce;
            end
        end
        check("dump_we_late", bus.mem_we, 0);
        check("dump_no_ce", ce_seen, 0);
        check("dump_step_count", step_count, 8);

        // Exit dump to IDLE: pass-through restored.
        dump_btn = 1'b1;
        cyc();
        dump_btn = 1'b0;
        check("exit_dump_active", dump_active, 0);
        check("exit_mem_addr", bus.mem_addr, 8'h77);
        check("exit_mem_we", bus.mem_we, 1);
        cyc();

        // Coincident dump and step in IDLE: dump wins, step dropped.
        dump_btn = 1'b1;
        step_btn = 1'b1;
        cyc();
        check("coinc_ce", cpu_ce, 0);
        check("coinc_dump", dump_active, 1);
        check("coinc_addr", bus.mem_addr, 2);
        dump_btn = 1'b0;
        step_btn = 1'b0;
        cyc();
        check("coinc_count", step_count, 8);

        // Exit dump with run_sw=1 goes to RUN; then reset with divider at 2.
        run_sw   = 1'b1;
        dump_btn = 1'b1;
        cyc();
        dump_btn = 1'b0;
        check("dump_to_run_active", dump_active, 0);
        cyc(2);
        reset  = 1'b1;
        run_sw = 1'b0;
        cyc();
        check("rrst_ce", cpu_ce, 0);
        check("rrst_count", step_count, 0);
        check("rrst_dump", dump_active, 0);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            pulses += int'(cpu_ce);
        end
        check("rrst_no_pulse", pulses, 0);
        step_btn = 1'b1;
        cyc();
        check("rrst_idle_step", cpu_ce, 1);
        step_btn = 1'b0;
        cyc();

        // Step held through reset produces an event right after reset.
        reset    = 1'b1;
        step_btn = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc();
        check("held_ce", cpu_ce, 1);
        check("held_count", step_count, 1);
        step_btn = 1'b0;
        cyc();
        check("held_ce_off", cpu_ce, 0);

`ifdef CPU_DEBUG_BREAKPOINT_EN
        // Breakpoint stops RUN, stays latched, and a step clears it.
        check("bp_hit_rst", bp_hit, 0);
        bp_addr      = 8'h10;
        bp_en        = 1'b1;
        bus.cpu_addr = 8'h0F;
        run_sw       = 1'b1;
        cyc();
        cyc(2);
        bus.cpu_addr = 8'h10;
        cyc();
        check("bp_hit_set", bp_hit, 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            pulses += int'(cpu_ce);
        end
        check("bp_no_pulse", pulses, 0);
        check("bp_hit_sticky", bp_hit, 1);
        step_btn = 1'b1;
        cyc();
        check("bp_hit_clear", bp_hit, 0);
        check("bp_step_ce", cpu_ce, 1);
        step_btn = 1'b0;
        run_sw   = 1'b0;
        bp_en    = 1'b0;
        cyc(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_debug_monitor.md
Name: cpu_debug_monitor

Overview:
- Parametrised single-clock successor to the board-level step/dump logic.
- Replaces the button-derived CPU clock and button-clocked dump counter with clock enables in the system clock domain.
- Sequences CPU execution in three modes: single step, free run at a divided rate, and memory dump.
- Owns the memory port mux between CPU and dump counter, and selects one of four words for the display controller.

Parameters:
- DATA_W, 16, memory and display word width.
- ADDR_W, 8, memory address width.
- RUN_DIV, 500, clk cycles between cpu_ce pulses in RUN mode; must be at least 2.
- DUMP_START, 0, first address visited in dump mode.
- DUMP_END, 2**ADDR_W-1, last address visited in dump mode; must be at least DUMP_START.

Ports:
- clk  in  1  system clock; sole clock of the block.
- reset  in  1  synchronous, active-high reset.
- step_btn  in  1  debounced step level; rising edge is the event.
- dump_btn  in  1  debounced dump toggle level; rising edge is the event.
- run_sw  in  1  level; 1 selects free-run mode.
- disp_sel  in  2  display source select.
- cpu_addr  in  ADDR_W  CPU memory address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_we  in  1  CPU write request.
- mem_rdata  in  DATA_W  memory read data.
- cpu_ce  out  1  one-cycle CPU clock-enable pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- disp_word  out  DATA_W  word for the display controller.
- dump_active  out  1  high while in DUMP.
- step_count  out  16  number of cpu_ce pulses since reset.

Behaviour:
- Edge detect: step_btn and dump_btn are each registered once. An event is cur & ~prev, asserted for one cycle. Both prev registers reset to 0, so a button held through reset produces an event on the first cycle after reset.
- FSM states: IDLE, RUN, DUMP. Reset state is IDLE.
- IDLE:
  - A step event gives cpu_ce=1 in the next cycle, exactly one pulse.
  - run_sw=1 moves to RUN.
  - A dump event moves to DUMP.
  - If dump and step events occur in the same cycle, dump wins and the step is dropped.
- RUN:
  - Divider counter runs 0..RUN_DIV-1. cpu_ce=1 in the cycle the counter equals RUN_DIV-1, giving period RUN_DIV.
  - The divider clears on entry, so the first pulse comes RUN_DIV cycles after entry.
  - run_sw=0 returns to IDLE; any pulse already issued in that cycle stands.
  - A dump event moves to DUMP (run_sw is ignored while in DUMP).
  - Step events are ignored.
- DUMP:
  - cpu_ce is held 0, mem_we is forced 0, and mem_addr = dump_ptr.
  - dump_ptr loads DUMP_START on entry.
  - Each step event advances dump_ptr by 1. At DUMP_END it wraps to DUMP_START.
  - A dump event exits: to RUN if run_sw=1, otherwise to IDLE. dump_ptr holds its value.
- Outside DUMP: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, all combinational pass-through.
- step_count increments on each cpu_ce pulse and wraps 0xFFFF->0.
- disp_word (combinational):
  - 0: mem_rdata.
  - 1: mem_addr, zero-extended to DATA_W.
  - 2: cpu_wdata.
  - 3: step_count, truncated or zero-extended to DATA_W.
- Reset values: cpu_ce=0, dump_active=0, step_count=0, dump_ptr=DUMP_START, divider=0, state=IDLE.
- Reset asserted mid-RUN or mid-DUMP returns the block to IDLE on the next clk edge, with no cpu_ce in that cycle.
- cpu_ce never asserts in two consecutive cycles.

Optional Feature:
- Macro: CPU_DEBUG_BREAKPOINT_EN.
- Defined:
  - Adds input bp_addr (ADDR_W) and input bp_en (1), and output bp_hit (1).
  - In RUN, when bp_en=1 and cpu_addr==bp_addr is sampled in a cycle with no cpu_ce pulse: the FSM goes to IDLE and bp_hit is set.
  - bp_hit is sticky until the next step event or reset.
  - The divider clears.
- Undefined: none of these ports exist and RUN stops only on run_sw=0 or a dump event.

Test Plan:
- Reset, then 3 step_btn rising edges spaced 10 cycles apart, run_sw=0 -> exactly 3 cpu_ce pulses, each one cycle after its edge; step_count=3.
- RUN_DIV=4, run_sw=1 held for 20 cycles -> cpu_ce pulses on cycles 4, 8, 12, 16, 20 after entry. Drop run_sw -> no further pulses.
- DUMP_START=2, DUMP_END=4, dump event then 4 step events -> mem_addr sequence 2, 3, 4, 2, 3; mem_we=0 even with cpu_we=1; cpu_ce stays 0.
- In DUMP, disp_sel=1 -> disp_word=0x0003 after 1 step; disp_sel=0 -> disp_word equals mem_rdata.
- Reset asserted during RUN with the divider at 2 -> next cycle state=IDLE, cpu_ce=0, step_count=0, dump_active=0.
- With CPU_DEBUG_BREAKPOINT_EN, bp_addr=0x10, bp_en=1, cpu_addr driven 0x0F then 0x10 in RUN -> return to IDLE with bp_hit=1, no further cpu_ce; a step event clears bp_hit.
